// File: rtl/sig_acq_pkg.sv
// rtl/sig_acq_pkg.sv - shared constants, state type and lane-slice helper for the SSI receive path
package sig_acq_pkg;

  localparam int SSI_LANES     = 4;
  localparam int SSI_WORD_BITS = 16;

  // ssi_clk, ssi_fss and the data lanes travel through one synchroniser together
  localparam int SSI_SYNC_W    = SSI_LANES + 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ssi_state_e;

  // Lane n's word sits at rx_data[lane_lsb(n, bits) +: bits]
  function automatic int lane_lsb(input int lane, input int bits);
    return lane * bits;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterised-width two-flop synchroniser with asynchronous active-high reset
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops resolve metastability on the asynchronous inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ssi_quad_rx.sv
// rtl/ssi_quad_rx.sv - quad-lane SSI receiver: oversampled frame detect, MSB-first deserialise, valid/ready output
module ssi_quad_rx
  import sig_acq_pkg::*;
#(
  parameter int WORD_BITS = SSI_WORD_BITS,
  parameter int TIMEOUT   = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ssi_clk,
  input  logic                           ssi_fss,
  input  logic [SSI_LANES-1:0]           ssi_xdat,
  output logic [SSI_LANES*WORD_BITS-1:0] rx_data,
  output logic                           rx_valid,
  input  logic                           rx_ready,
  output logic                           rx_overflow,
  output logic                           frm_err,
  output logic                           busy
);

  localparam int BCW = $clog2(WORD_BITS + 1);
  localparam int TW  = $clog2(TIMEOUT) + 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_BITS - 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  logic [SSI_SYNC_W-1:0] sync_in;
  logic [SSI_SYNC_W-1:0] sync_s2;
  logic [SSI_SYNC_W-1:0] s3_q, s3_d;

  ssi_state_e                           state_q, state_d;
  logic [BCW-1:0]                       bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]                        tmo_cnt_q, tmo_cnt_d;
  logic [SSI_LANES-1:0][WORD_BITS-1:0]  shift_q, shift_d;
  logic                                 done_q, done_d;
  logic [SSI_LANES*WORD_BITS-1:0]       rx_data_q, rx_data_d;
  logic                                 rx_valid_q, rx_valid_d;
  logic                                 rx_ovf_q, rx_ovf_d;
  logic                                 frm_err_q, frm_err_d;
  logic                                 busy_q, busy_d;

  logic                 sample_evt;
  logic                 smp_fss;
  logic [SSI_LANES-1:0] smp_dat;

  // Bit 0 = ssi_clk, bit 1 = ssi_fss, bits 5:2 = lanes 0..3
  assign sync_in = {ssi_xdat, ssi_fss, ssi_clk};

  sync_2ff #(
    .WIDTH (SSI_SYNC_W)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sync_in),
    .q   (sync_s2)
  );

  // Falling edge of the delayed ssi_clk; fss and data come from the same stage so they stay aligned
  assign s3_d       = sync_s2;
  assign sample_evt = s3_q[0] & ~sync_s2[0];
  assign smp_fss    = s3_q[1];
  assign smp_dat    = s3_q[SSI_SYNC_W-1:2];

  // Frame FSM: fss arms SHIFT, lanes shift MSB first, resync on early fss, abort on stalled ssi_clk
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    frm_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_cnt_d = '0;
        if (sample_evt && smp_fss) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (sample_evt) begin
          tmo_cnt_d = '0;
          // An fss on the final bit still completes the frame; the next frame needs its own fss
          if (smp_fss && (bit_cnt_q != LAST_BIT)) begin
            frm_err_d = 1'b1;
            bit_cnt_d = '0;
            shift_d   = '0;
          end else begin
            for (int n = 0; n < SSI_LANES; n++) begin
              shift_d[n] = {shift_q[n][WORD_BITS-2:0], smp_dat[n]};
            end
            if (bit_cnt_q == LAST_BIT) begin
              done_d    = 1'b1;
              bit_cnt_d = '0;
              state_d   = ST_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          frm_err_d = 1'b1;
          tmo_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register: accept clears valid, completed frame loads unless an unconsumed frame blocks it
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ovf_d   = 1'b0;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_valid_d = 1'b1;
        for (int n = 0; n < SSI_LANES; n++) begin
          rx_data_d[lane_lsb(n, WORD_BITS) +: WORD_BITS] = shift_q[n];
        end
      end else begin
        rx_ovf_d = 1'b1;
      end
    end
    busy_d = (state_d == ST_SHIFT);
  end

  // State and datapath registers; reset discards any partial frame immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_q       <= '0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
      frm_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      s3_q       <= s3_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovf_q   <= rx_ovf_d;
      frm_err_q  <= frm_err_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overflow = rx_ovf_q;
  assign frm_err     = frm_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ssi_quad_rx.sv
// tb/tb_ssi_quad_rx.sv - directed self-checking bench for ssi_quad_rx
module tb_ssi_quad_rx;

  localparam int WB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ssi_clk;
  logic          ssi_fss;
  logic [3:0]    ssi_xdat;
  logic [4*WB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          rx_overflow;
  logic          frm_err;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_ferr = 0;
  int n_ovf  = 0;

  always #5 clk = ~clk;

  ssi_quad_rx #(
    .WORD_BITS (WB),
    .TIMEOUT   (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ssi_clk     (ssi_clk),
    .ssi_fss     (ssi_fss),
    .ssi_xdat    (ssi_xdat),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_overflow (rx_overflow),
    .frm_err     (frm_err),
    .busy        (busy)
  );

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (frm_err)     n_ferr++;
    if (rx_overflow) n_ovf++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One fss period, then nbits data periods (MSB first); ssi_clk high 4 clk, low >= 4 clk.
  // On the final bit of a full frame, records clk edges from the falling edge until rx_valid is seen.
  task automatic send_frame(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3,
                            input int nbits, input bit ready_pulse,
                            output int lat, output logic [63:0] cap);
    logic       fss;
    logic [3:0] d;
    bit         last;
    int         b;
    lat = 0;
    cap = '0;
    for (int p = 0; p <= nbits; p++) begin
      if (p == 0) begin
        fss = 1'b1;
        d   = 4'h0;
      end else begin
        b   = WB - p;
        fss = 1'b0;
        d   = {w3[b], w2[b], w1[b], w0[b]};
      end
      last     = (p == WB);
      ssi_clk  = 1'b1;
      ssi_fss  = fss;
      ssi_xdat = d;
      repeat (4) @(negedge clk);
      ssi_clk = 1'b0;
      for (int i = 1; i <= (last ? 6 : 4); i++) begin
        @(posedge clk);
        #1;
        if (last && ready_pulse && i == 3) rx_ready = 1'b1;
        if (last && ready_pulse && i == 4) rx_ready = 1'b0;
        if (last && lat == 0 && rx_valid) begin
          lat = i;
          cap = rx_data;
        end
      end
      @(negedge clk);
    end
  endtask

  int          lat;
  logic [63:0] cap;
  int          f0;
  int          o0;

  initial begin
    rst      = 1'b0;
    ssi_clk  = 1'b0;
    ssi_fss  = 1'b0;
    ssi_xdat = 4'h0;
    rx_ready = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rx_data",  rx_data,     64'h0);
    check("rst_rx_valid", rx_valid,    64'h0);
    check("rst_ovf",      rx_overflow, 64'h0);
    check("rst_frm_err",  frm_err,     64'h0);
    check("rst_busy",     busy,        64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal frame, consumer always ready
    rx_ready = 1'b1;
    f0 = n_ferr;
    send_frame(16'hA55A, 16'h1234, 16'hFFFF, 16'h0001, WB, 1'b0, lat, cap);
    n_cmp++;
    assert (lat == 4 || lat == 5) else begin
      n_fail++;
      $error("FAIL nom_latency: observed %0d expected 4..5", lat);
    end
    check("nom_data",    cap,                 64'h0001_FFFF_1234_A55A);
    check("nom_frm_err", 64'(n_ferr - f0),    64'd0);
    check("nom_valid_clears", rx_valid,       64'h0);
    check("nom_busy_idle",    busy,           64'h0);

    // Backpressure: second frame is dropped, first is held
    rx_ready = 1'b0;
    o0 = n_ovf;
    send_frame(16'h1111, 16'h1111, 16'h1111, 16'h1111, WB, 1'b0, lat, cap);
    send_frame(16'h2222, 16'h2222, 16'h2222, 16'h2222, WB, 1'b0, lat, cap);
    check("bp_valid",  rx_valid,            64'h1);
    check("bp_data",   rx_data,             64'h1111_1111_1111_1111);
    check("bp_ovf",    64'(n_ovf - o0),     64'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    check("bp_drained", rx_valid,           64'h0);

    // Accept and reload in the same cycle
    o0 = n_ovf;
    send_frame(16'h3333, 16'h3333, 16'h3333, 16'h3333, WB, 1'b0, lat, cap);
    send_frame(16'h4444, 16'h4444, 16'h4444, 16'h4444, WB, 1'b1, lat, cap);
    check("sim_data",  rx_data,             64'h4444_4444_4444_4444);
    check("sim_valid", rx_valid,            64'h1);
    check("sim_ovf",   64'(n_ovf - o0),     64'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("sim_drained", rx_valid,          64'h0);

    // Resync: fss returns after 7 bits
    f0 = n_ferr;
    send_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 7, 1'b0, lat, cap);
    send_frame(16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, WB, 1'b0, lat, cap);
    check("rsy_frm_err", 64'(n_ferr - f0),  64'd1);
    check("rsy_data",    cap,               64'hBEEF_BEEF_BEEF_BEEF);

    // Timeout: ssi_clk stops after 5 bits
    f0 = n_ferr;
    send_frame(16'h5555, 16'h5555, 16'h5555, 16'h5555, 5, 1'b0, lat, cap);
    repeat (1000) @(negedge clk);
    check("tmo_busy_before", busy,             64'h1);
    check("tmo_err_before",  64'(n_ferr - f0), 64'd0);
    repeat (40) @(negedge clk);
    check("tmo_err_after",   64'(n_ferr - f0), 64'd1);
    check("tmo_busy_after",  busy,             64'h0);
    send_frame(16'hC3C3, 16'h3C3C, 16'h0F0F, 16'hF0F0, WB, 1'b0, lat, cap);
    check("tmo_next_data",   cap,              64'hF0F0_0F0F_3C3C_C3C3);

    // Reset mid-frame with an unconsumed frame pending
    rx_ready = 1'b0;
    send_frame(16'h7777, 16'h7777, 16'h7777, 16'h7777, WB, 1'b0, lat, cap);
    send_frame(16'h9999, 16'h9999, 16'h9999, 16'h9999, 10, 1'b0, lat, cap);
    check("mrst_busy_before", busy,         64'h1);
    rst = 1'b1;
    #1;
    check("mrst_valid", rx_valid,           64'h0);
    check("mrst_data",  rx_data,            64'h0);
    check("mrst_busy",  busy,               64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_ready = 1'b1;
    @(negedge clk);
    f0 = n_ferr;
    send_frame(16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, WB, 1'b0, lat, cap);
    check("mrst_next_data", cap,             64'h0F0F_0F0F_0F0F_0F0F);
    check("mrst_frm_err",   64'(n_ferr - f0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ssi_quad_rx.md
Name: ssi_quad_rx

Overview:
Receiving end of the quad-lane SSI link that carries acquisition data between the FPGA and the ARM (ssi_clk, ssi_fss, four data lanes). It oversamples the SSI pins in the `clk` domain, detects frames, and deserialises one word per lane, MSB first. It presents the four words on a valid/ready output register. It serves as the FPGA loopback checker for the SSI transmit path and as the inbound path from a second SSI master.

Parameters:
WORD_BITS, 16, bits per lane per frame (range 4..32)
TIMEOUT, 1024, clk cycles with no ssi_clk falling edge before an in-progress frame is aborted

Ports:
clk  in  1  system clock (110 MHz); ssi_clk must be <= clk/8
rst  in  1  asynchronous, active-high reset
ssi_clk  in  1  SSI bit clock, asynchronous to clk
ssi_fss  in  1  frame sync, high for one ssi_clk period before the MSB
ssi_xdat  in  4  lane data; bit n = lane n
rx_data  out  4*WORD_BITS  lane n word at bits [n*WORD_BITS +: WORD_BITS]
rx_valid  out  1  rx_data holds an unconsumed frame
rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready
rx_overflow  out  1  one-cycle pulse: completed frame dropped
frm_err  out  1  one-cycle pulse: framing error or timeout
busy  out  1  high while in SHIFT

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: rx_data=0, rx_valid=0, rx_overflow=0, frm_err=0, busy=0. Internally, state=IDLE, bit_cnt=0, shift registers=0, timeout counter=0, synchronisers=0.
- Input path:
  - ssi_clk, ssi_fss and ssi_xdat[3:0] pass through an identical 2-FF synchroniser, then one extra stage.
  - A sample event is a falling edge of the delayed ssi_clk (stage3=1, stage2=0).
  - At the event, fss and data are taken from stage3, so all signals stay aligned.
- Sampling: on the ssi_clk falling edge only. The transmitter drives on the rising edge.
- State IDLE:
  - At a sample event with fss=1: go to SHIFT, clear bit_cnt and the timeout counter.
  - Otherwise stay in IDLE.
- State SHIFT:
  - At a sample event with fss=0: each lane shift register shifts left and takes its lane bit in the LSB; bit_cnt increments.
  - When the sample that makes bit_cnt reach WORD_BITS is taken: the frame is complete. Go to IDLE.
  - At a sample event with fss=1: pulse frm_err, discard partial data, restart with bit_cnt=0 and stay in SHIFT. This is a resync to the new frame.
  - The timeout counter increments on every clk without a sample event and clears on each event.
  - At TIMEOUT-1: pulse frm_err and go to IDLE. Partial data is discarded.
- Frame completion, handled in the clk after the last sample:
  - If rx_valid=0, or rx_valid && rx_ready in the same cycle: load rx_data and set rx_valid=1. A simultaneous accept and reload does not pulse rx_overflow.
  - If rx_valid=1 && rx_ready=0: keep the old rx_data, pulse rx_overflow, and drop the new frame.
- Handshake:
  - rx_valid clears on the cycle after rx_valid && rx_ready, unless a new frame loads.
  - rx_data is stable while rx_valid=1 && rx_ready=0.
- Latency: rx_valid rises 4 clk cycles after the last ssi_clk falling edge reaches the pin (+1 cycle of synchroniser uncertainty).
- busy tracks state==SHIFT, registered.
- An fss=1 edge coincident with frame completion counts as completion only. The next frame needs a new fss.
- Reset mid-frame: everything returns to reset values immediately, and the partial frame is lost.

Decomposition:
- Package sig_acq_pkg holds:
  - SSI_LANES=4
  - the default WORD_BITS
  - the state enum {IDLE, SHIFT}
  - the lane-slice helper constant
- Sub-module sync_2ff: a parameterised-width 2-FF synchroniser with asynchronous active-high reset. It is instantiated once, 6 bits wide (clk, fss, 4 data lanes).
- All remaining logic (edge detect, FSM, shifters, output register) sits in ssi_quad_rx.

Test Plan:
- Nominal frame: ssi_clk = clk/8, fss pulse, lanes 0..3 carry 16'hA55A, 16'h1234, 16'hFFFF, 16'h0001; rx_ready=1 -> one rx_valid pulse with rx_data=64'h0001_FFFF_1234_A55A, latency 4 to 5 clk after the last falling edge, frm_err=0.
- Backpressure: two back-to-back frames (0x1111…, 0x2222…) with rx_ready=0 -> rx_data holds the 0x1111 frame, one rx_overflow pulse; after rx_ready=1 for one cycle, rx_valid=0.
- Simultaneous accept and reload: assert rx_ready on exactly the completion cycle of frame 2 -> rx_data becomes frame 2, rx_valid stays 1, no rx_overflow.
- Resync: fss reasserted after 7 of 16 bits, then a full frame 0xBEEF on all lanes -> one frm_err pulse, then rx_data = 4×16'hBEEF.
- Timeout: stop ssi_clk after 5 bits, wait 1024 clk -> frm_err pulse, busy=0; the next full frame is received correctly.
- Reset mid-frame: assert rst after 10 bits -> all outputs 0 asynchronously; after release, a full frame 0x0F0F is received intact.
